// File: rtl/mseq_sync_if.sv
// Bit-stream and status bundle between an M-sequence source/monitor and the sync checker.
interface mseq_sync_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    logic             bit_in;
    logic             bit_valid;
    logic [WIDTH-1:0] type_f;
    logic             err_clr;
    logic [WIDTH-1:0] fase_est;
    logic             pred;
    logic             locked;
    logic             bit_err;
    logic [ERR_W-1:0] err_total;

    modport master (
        output bit_in, bit_valid, type_f, err_clr,
        input  fase_est, pred, locked, bit_err, err_total
    );

    modport slave (
        input  bit_in, bit_valid, type_f, err_clr,
        output fase_est, pred, locked, bit_err, err_total
    );
endinterface

// File: rtl/mseq_sync_checker.sv
// Self-synchronising M-sequence receiver: loads state from the stream, acquires,
// then flywheels on its own prediction while counting bit errors.
module mseq_sync_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 8,
    parameter int LOSS_ERR = 3,
    parameter int ERR_W    = 8
) (
    input logic clk,
    input logic rst,
    mseq_sync_if.slave sif
);
    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_ACQ  = 2'd1;
    localparam logic [1:0] ST_LOCK = 2'd2;

    localparam int                LCW        = $clog2(WIDTH + 1);
    localparam logic [LCW-1:0]    LOAD_LAST  = LCW'(WIDTH - 1);
    localparam logic [LCW-1:0]    LOAD_ONE   = LCW'(1);
    localparam logic [7:0]        MATCH_LAST = 8'(LOCK_CNT - 1);
    localparam logic [3:0]        MISS_LAST  = 4'(LOSS_ERR - 1);
    localparam logic [ERR_W-1:0]  ERR_ONE    = ERR_W'(1);
    localparam logic [ERR_W-1:0]  ERR_MAX    = {ERR_W{1'b1}};

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] fase_reg, fase_next;
    logic [LCW-1:0]   load_cnt_reg, load_cnt_next;
    logic [7:0]       match_cnt_reg, match_cnt_next;
    logic [3:0]       miss_cnt_reg, miss_cnt_next;
    logic             locked_reg, locked_next;
    logic             bit_err_reg, bit_err_next;
    logic [ERR_W-1:0] err_total_reg, err_total_next;

    logic [WIDTH-1:0] tap_bits;
    logic             pred;
    logic [WIDTH-1:0] shift_in;
    logic [WIDTH-1:0] shift_pred;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap
            assign tap_bits[gi] = fase_reg[gi] & sif.type_f[gi];
        end
    endgenerate

    assign pred       = ^tap_bits;
    assign shift_in   = {sif.bit_in, fase_reg[WIDTH-1:1]};
    assign shift_pred = {pred, fase_reg[WIDTH-1:1]};

    always_comb begin
        state_next     = state_reg;
        fase_next      = fase_reg;
        load_cnt_next  = load_cnt_reg;
        match_cnt_next = match_cnt_reg;
        miss_cnt_next  = miss_cnt_reg;
        locked_next    = locked_reg;
        bit_err_next   = 1'b0;
        err_total_next = err_total_reg;

        if (sif.bit_valid) begin
            case (state_reg)
                ST_LOAD: begin
                    fase_next = shift_in;
                    if (load_cnt_reg == LOAD_LAST) begin
                        load_cnt_next = '0;
                        // An all-zero state is the LFSR lock-up point; reload instead.
                        if (shift_in != '0) begin
                            state_next     = ST_ACQ;
                            match_cnt_next = '0;
                        end
                    end else begin
                        load_cnt_next = load_cnt_reg + LOAD_ONE;
                    end
                end
                ST_ACQ: begin
                    if (sif.bit_in == pred) begin
                        fase_next      = shift_in;
                        match_cnt_next = match_cnt_reg + 8'd1;
                        if (match_cnt_reg == MATCH_LAST) begin
                            state_next    = ST_LOCK;
                            locked_next   = 1'b1;
                            miss_cnt_next = '0;
                        end
                    end else begin
                        bit_err_next  = 1'b1;
                        load_cnt_next = '0;
                        state_next    = ST_LOAD;
                    end
                end
                ST_LOCK: begin
                    // Flywheel: the received bit never enters the state here.
                    fase_next = shift_pred;
                    if (sif.bit_in == pred) begin
                        miss_cnt_next = '0;
                    end else begin
                        bit_err_next  = 1'b1;
                        miss_cnt_next = miss_cnt_reg + 4'd1;
                        if (err_total_reg != ERR_MAX)
                            err_total_next = err_total_reg + ERR_ONE;
                        if (miss_cnt_reg == MISS_LAST) begin
                            locked_next   = 1'b0;
                            load_cnt_next = '0;
                            state_next    = ST_LOAD;
                        end
                    end
                end
                default: begin
                    state_next    = ST_LOAD;
                    load_cnt_next = '0;
                    locked_next   = 1'b0;
                end
            endcase
        end

        if (sif.err_clr)
            err_total_next = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_LOAD;
            fase_reg      <= '0;
            load_cnt_reg  <= '0;
            match_cnt_reg <= '0;
            miss_cnt_reg  <= '0;
            locked_reg    <= 1'b0;
            bit_err_reg   <= 1'b0;
            err_total_reg <= '0;
        end else begin
            state_reg     <= state_next;
            fase_reg      <= fase_next;
            load_cnt_reg  <= load_cnt_next;
            match_cnt_reg <= match_cnt_next;
            miss_cnt_reg  <= miss_cnt_next;
            locked_reg    <= locked_next;
            bit_err_reg   <= bit_err_next;
            err_total_reg <= err_total_next;
        end
    end

    assign sif.fase_est  = fase_reg;
    assign sif.pred      = pred;
    assign sif.locked    = locked_reg;
    assign sif.bit_err   = bit_err_reg;
    assign sif.err_total = err_total_reg;
endmodule

// File: tb/tb_mseq_sync_checker.sv
// Directed bench for mseq_sync_checker: lock, isolated error, loss/relock,
// acquisition false start, all-zero load, reset, error-counter saturation and clear.
module tb_mseq_sync_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    logic [3:0] gen_state;
    logic       err_seen;

    mseq_sync_if #(.WIDTH(4), .ERR_W(2)) sif ();

    mseq_sync_checker #(
        .WIDTH(4), .LOCK_CNT(8), .LOSS_ERR(3), .ERR_W(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp_v);
    endtask

    // One strobed bit, then sample 1 time unit after the capturing edge.
    task automatic send(input logic b);
        sif.bit_in    = b;
        sif.bit_valid = 1'b1;
        @(posedge clk);
        #1;
        sif.bit_valid = 1'b0;
        err_seen = err_seen | sif.bit_err;
    endtask

    task automatic idle();
        sif.bit_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Reference generator (taps 0011): emit feedback bit, shift it into the MSB.
    task automatic send_gen(input logic inv);
        logic b;
        b = ^(gen_state & 4'b0011);
        gen_state = {b, gen_state[3:1]};
        send(b ^ inv);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sif.bit_valid = 1'b1;
        sif.bit_in    = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sif.bit_valid = 1'b0;
    endtask

    initial begin
        sif.bit_in    = 1'b0;
        sif.bit_valid = 1'b0;
        sif.type_f    = 4'b0011;
        sif.err_clr   = 1'b0;
        err_seen      = 1'b0;
        gen_state     = 4'b1000;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_fase", 32'(sif.fase_est), 0);
        chk("rst_locked", 32'(sif.locked), 0);
        chk("rst_err", 32'(sif.bit_err), 0);
        chk("rst_total", 32'(sif.err_total), 0);
        chk("rst_pred", 32'(sif.pred), 0);

        // Lock on clean stream
        repeat (4) send_gen(1'b0);
        chk("load_fase", 32'(sif.fase_est), 32'h0000000C);
        repeat (7) send_gen(1'b0);
        chk("lock_early", 32'(sif.locked), 0);
        send_gen(1'b0);
        chk("lock_at12", 32'(sif.locked), 1);
        chk("lock_fase", 32'(sif.fase_est), 32'h00000007);
        chk("lock_noerr", 32'(err_seen), 0);

        // Isolated error: flywheel keeps the true sequence
        send_gen(1'b1);
        chk("iso_err", 32'(sif.bit_err), 1);
        chk("iso_total", 32'(sif.err_total), 1);
        chk("iso_locked", 32'(sif.locked), 1);
        chk("iso_fase", 32'(sif.fase_est), 32'h00000003);
        send_gen(1'b0);
        chk("iso_clean", 32'(sif.bit_err), 0);
        chk("iso_fase2", 32'(sif.fase_est), 32'h00000001);

        // err_clr on an idle cycle
        sif.err_clr = 1'b1;
        idle();
        sif.err_clr = 1'b0;
        chk("clr_idle", 32'(sif.err_total), 0);
        chk("idle_noerr", 32'(sif.bit_err), 0);

        // Loss after three consecutive errors, then relock
        send_gen(1'b1);
        send_gen(1'b1);
        chk("loss_hold", 32'(sif.locked), 1);
        send_gen(1'b1);
        chk("loss_drop", 32'(sif.locked), 0);
        chk("loss_total", 32'(sif.err_total), 3);
        repeat (11) send_gen(1'b0);
        chk("relock_early", 32'(sif.locked), 0);
        send_gen(1'b0);
        chk("relock", 32'(sif.locked), 1);
        chk("relock_fase", 32'(sif.fase_est), 32'(gen_state));

        // Reset while locked, with a strobe present
        do_reset();
        chk("rst2_fase", 32'(sif.fase_est), 0);
        chk("rst2_locked", 32'(sif.locked), 0);
        chk("rst2_total", 32'(sif.err_total), 0);
        chk("rst2_err", 32'(sif.bit_err), 0);

        // ACQ false start on bit 6
        gen_state = 4'b1000;
        repeat (5) send_gen(1'b0);
        send_gen(1'b1);
        chk("acq_err", 32'(sif.bit_err), 1);
        chk("acq_total", 32'(sif.err_total), 0);
        chk("acq_locked", 32'(sif.locked), 0);
        chk("acq_fase", 32'(sif.fase_est), 32'h00000006);
        repeat (11) send_gen(1'b0);
        chk("acq_early", 32'(sif.locked), 0);
        send_gen(1'b0);
        chk("acq_relock", 32'(sif.locked), 1);

        // All-zero load is rejected and the load count restarts
        do_reset();
        repeat (4) send(1'b0);
        chk("zero_fase", 32'(sif.fase_est), 0);
        chk("zero_locked", 32'(sif.locked), 0);
        gen_state = 4'b1000;
        repeat (4) send_gen(1'b0);
        chk("zero_reload", 32'(sif.fase_est), 32'h0000000C);
        repeat (7) send_gen(1'b0);
        chk("zero_early", 32'(sif.locked), 0);
        send_gen(1'b0);
        chk("zero_lock", 32'(sif.locked), 1);

        // Saturation of a 2-bit counter, then clear racing an increment
        for (int i = 0; i < 5; i++) begin
            send_gen(1'b1);
            chk("sat_total", 32'(sif.err_total), (i < 3) ? i + 1 : 3);
            send_gen(1'b0);
        end
        chk("sat_locked", 32'(sif.locked), 1);
        sif.err_clr = 1'b1;
        send_gen(1'b1);
        sif.err_clr = 1'b0;
        chk("clr_win", 32'(sif.err_total), 0);
        chk("clr_err", 32'(sif.bit_err), 1);
        idle();
        chk("clr_after", 32'(sif.bit_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mseq_sync_checker.md
Name: mseq_sync_checker

Overview:
- Receive-side companion to the team's 4-bit M-sequence generator.
- Consumes the serial feedback-bit stream that the generator emits and self-synchronises a local copy of the generator state from it.
- Once synchronised, predicts every following bit and reports lock status and bit errors.
- Sits at the sink end of the M-sequence link (BER test / despreader front end); uses the same tap-mask convention as the generator.

Parameters:
- WIDTH, 4, shift-register length; tap mask and state width.
- LOCK_CNT, 8, consecutive correct predictions in ACQ before declaring lock (1..255).
- LOSS_ERR, 3, consecutive mispredictions in LOCK before dropping lock (1..15).
- ERR_W, 8, width of the saturating total-error counter.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- bit_in  in  1  received sequence bit; sampled only when bit_valid=1.
- bit_valid  in  1  one-cycle strobe, one per received bit (equivalent of generator control).
- type_f  in  WIDTH  tap mask, same encoding as the generator; must be nonzero.
- err_clr  in  1  synchronous clear of err_total.
- fase_est  out  WIDTH  local state estimate (registered).
- pred  out  1  predicted next bit = XOR-reduce(fase_est & type_f), combinational from registers.
- locked  out  1  high while in LOCK (registered).
- bit_err  out  1  one-cycle pulse: valid bit mismatched prediction in ACQ or LOCK.
- err_total  out  ERR_W  saturating count of bit_err pulses while locked.

Behaviour:
- Reset (rst=1 at posedge): state=LOAD, fase_est=0, load_cnt=0, match_cnt=0, miss_cnt=0, locked=0, bit_err=0, err_total=0. Reset dominates all other inputs, including mid-operation.
- Shift convention matches the generator: new bit enters the MSB, so fase_est <= {b, fase_est[WIDTH-1:1]}.
- All updates occur only on cycles with bit_valid=1. bit_err is 0 on every other cycle.
- Outputs are registered: results appear the cycle after the bit_valid strobe.
- LOAD: shift bit_in into fase_est and increment load_cnt. When the WIDTH-th bit is shifted in:
  - if the resulting state is nonzero, go to ACQ with match_cnt=0;
  - if the resulting state is all-zero (illegal), clear load_cnt and stay in LOAD.
  - No comparisons are made in LOAD; bit_err stays 0.
- ACQ: compare bit_in with pred.
  - Match: shift bit_in and increment match_cnt. When match_cnt reaches LOCK_CNT, go to LOCK with locked=1 and miss_cnt=0.
  - Mismatch: pulse bit_err, set load_cnt=0, go to LOAD (the mismatched bit is discarded, not loaded).
- LOCK (flywheel): always shift pred, never bit_in, so channel errors cannot corrupt the state.
  - Match: miss_cnt=0.
  - Mismatch: pulse bit_err, increment err_total (saturating at 2^ERR_W-1), increment miss_cnt.
  - When miss_cnt reaches LOSS_ERR: locked=0, load_cnt=0, go to LOAD.
- err_clr: clears err_total. If an increment occurs in the same cycle, clear wins and err_total=0.
- Changing type_f while locked is not special-cased; the resulting mispredictions are handled by the normal loss path.
- Back-to-back strobes (bit_valid high every cycle) must be supported at full rate.

Test Plan:
1. Lock: type_f=4'b0011, generator seeded with 1000, stream 0,0,1,1,0,1,0,1,1,1,1,0,0,0,1 repeated → after bit 4, fase_est=1100, state=ACQ; locked=1 one cycle after bit 12; bit_err=0 throughout.
2. Isolated error: while locked, invert one bit → exactly one bit_err pulse, err_total=1, locked stays 1, fase_est continues the correct sequence.
3. Loss: while locked, invert 3 consecutive bits → err_total=3, locked=0 after the 3rd bit; on resumed clean stream, relock after 4+8 further bits.
4. ACQ false start: invert bit 6 → bit_err pulse, return to LOAD, no err_total increment; relocks on clean data.
5. All-zero load and reset: feed 0,0,0,0 → stays in LOAD with load_cnt=0. Assert rst while locked → all outputs return to reset values on the next cycle.
6. Saturation: with ERR_W=2, force 5 isolated errors while locked → err_total holds at 3. Assert err_clr together with an error → err_total=0.
